// File: rtl/wb_ram512_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ram512_ctrl
//
// Connects a Wishbone slave port to a single-port 64-bit RAM with byte-lane
// write enables and a registered read. After reset, the controller can
// zero-fill the whole RAM (INIT state). It then serves bus requests at a rate
// of one per cycle (RUN state).
//
// Parameters
//   BITS            word address width; RAM depth is 2**BITS words of 64 bits
//   CLEAR_ON_RESET  1: zero-fill the RAM after reset, 0: go straight to RUN
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   wb_cyc     bus cycle
//   wb_stb     request strobe
//   wb_we      1 = write, 0 = read
//   wb_sel     byte lane enables (bit i covers data[8i+7:8i])
//   wb_adr     word address
//   wb_dat_w   write data
//   wb_dat_r   read data, valid with wb_ack on reads, otherwise 0
//   wb_ack     request completion, one cycle after acceptance
//   wb_stall   request not accepted this cycle
//   init_done  high while in RUN
//   ram_en     RAM port enable
//   ram_we     RAM byte write enables
//   ram_a      RAM address
//   ram_di     RAM write data
//   ram_do     RAM read data, valid one cycle after an enabled read
// -----------------------------------------------------------------------------
module wb_ram512_ctrl #(
    parameter int BITS           = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [7:0]      wb_sel,
    input  logic [BITS-1:0] wb_adr,
    input  logic [63:0]     wb_dat_w,
    output logic [63:0]     wb_dat_r,
    output logic            wb_ack,
    output logic            wb_stall,
    output logic            init_done,
    output logic            ram_en,
    output logic [7:0]      ram_we,
    output logic [BITS-1:0] ram_a,
    output logic [63:0]     ram_di,
    input  logic [63:0]     ram_do
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    state_t          state_reg;
    state_t          state_next;
    logic [BITS-1:0] cnt_reg;
    logic [BITS-1:0] cnt_next;
    logic            ack_reg;
    logic            rd_reg;

    // The reset is synchronous, but the outputs in the cycle where RST is high
    // must already look like the reset state. So the output logic uses these
    // "effective" copies instead of the raw registers.
    state_t          cur_state;
    logic [BITS-1:0] cur_cnt;
    logic            accept;
    logic            last_addr;
    logic [7:0]      req_we;

    assign cur_state = RST ? RESET_STATE : state_reg;
    assign cur_cnt   = RST ? '0 : cnt_reg;
    assign accept    = ~RST & (cur_state == ST_RUN) & wb_cyc & wb_stb;
    assign last_addr = (cnt_reg == {BITS{1'b1}});

    // Per-lane write enables. Reads drive no lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane_we
            assign req_we[gi] = wb_we & wb_sel[gi];
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= accept;
            rd_reg    <= accept & ~wb_we;
        end
    end

    // ----------------------------------------------------------- next state
    // The fill covers each address exactly once. When the write to the last
    // address completes, the controller moves to RUN and the counter is frozen.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_INIT) begin
            if (last_addr) begin
                state_next = ST_RUN;
            end else begin
                cnt_next = cnt_reg + BITS'(1);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 8'h00;
        ram_a    = '0;
        ram_di   = '0;
        wb_stall = 1'b1;
        case (cur_state)
            ST_INIT: begin
                ram_en = 1'b1;
                ram_we = 8'hFF;
                ram_a  = cur_cnt;
            end
            ST_RUN: begin
                // No request can be taken while reset is held.
                wb_stall = RST;
                if (accept) begin
                    ram_en = 1'b1;
                    ram_we = req_we;
                    ram_a  = wb_adr;
                    ram_di = wb_dat_w;
                end
            end
            default: ;
        endcase
    end

    // A pending ack is dropped if the master has abandoned the cycle. It is
    // also dropped if reset arrives first. The RAM access itself already took
    // place when the request was accepted.
    assign wb_ack    = ack_reg & wb_cyc & ~RST;
    assign wb_dat_r  = (wb_ack & rd_reg) ? ram_do : 64'h0;
    assign init_done = (cur_state == ST_RUN);

endmodule

// File: tb/tb_wb_ram512_ctrl.sv
module tb_wb_ram512_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_sel = 8'h00;
    logic [8:0]  wb_adr = '0;
    logic [63:0] wb_dat_w = '0;
    logic [63:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_stall;
    logic        init_done;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [8:0]  ram_a;
    logic [63:0] ram_di;
    logic [63:0] ram_do = '0;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    wb_ram512_ctrl #(.BITS(9), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .wb_stall (wb_stall),
        .init_done(init_done),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_a    (ram_a),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    // RAM model: byte-lane writes, registered read, 0 after a disabled cycle.
    // Preloaded with non-zero contents so the zero-fill is observable.
    logic [63:0] mem [0:511];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
    always @(posedge CLK) begin
        if (ram_en) begin
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end else begin
            ram_do <= '0;
        end
    end

    typedef struct {
        logic        we;
        logic [7:0]  sel;
        logic [8:0]  adr;
        logic [63:0] dat;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic we, input logic [7:0] sel, input logic [8:0] adr,
                       input logic [63:0] dat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_sel = sel; wb_adr = adr; wb_dat_w = dat;
    endtask

    task automatic idle();
        wb_cyc = 1'b1; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = 8'h00; wb_adr = '0; wb_dat_w = '0;
    endtask

    // One isolated transaction: request cycle, then the ack cycle.
    task automatic do_txn(input vec_t v);
        step();
        req(v.we, v.sel, v.adr, v.dat);
        #1;
        chk($sformatf("req_en a=%h", v.adr), 64'(ram_en), 64'd1);
        chk($sformatf("req_a a=%h", v.adr), 64'(ram_a), 64'(v.adr));
        chk($sformatf("req_we a=%h", v.adr), 64'(ram_we), 64'(v.we ? v.sel : 8'h00));
        step();
        idle();
        #1;
        chk($sformatf("ack a=%h we=%0d", v.adr, v.we), 64'(wb_ack), 64'd1);
        chk($sformatf("dat_r a=%h we=%0d", v.adr, v.we), wb_dat_r, v.exp_rd);
    endtask

    // Counts stall cycles from the current cycle, which is the first cycle
    // after reset. It also checks the fill sequence and that no ack appears.
    // It stops early once stop_at cycles have been seen.
    task automatic wait_init(input int stop_at, output int n, output int bad, output int acks);
        n = 0; bad = 0; acks = 0;
        while (wb_stall && n < stop_at) begin
            if (ram_en !== 1'b1 || ram_we !== 8'hFF || ram_di !== 64'h0 || ram_a !== n[8:0])
                bad++;
            if (wb_ack !== 1'b0) acks++;
            if (n == 20) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
            n++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, acks;
        logic [63:0] burst_exp [4];

        vecs[0]  = '{1'b0, 8'hFF, 9'h1FF, 64'h0, 64'h0};
        vecs[1]  = '{1'b1, 8'hFF, 9'h005, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[2]  = '{1'b0, 8'hFF, 9'h005, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[3]  = '{1'b1, 8'h0F, 9'h005, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[4]  = '{1'b0, 8'hFF, 9'h005, 64'h0, 64'h0123_4567_FFFF_FFFF};
        vecs[5]  = '{1'b1, 8'hFF, 9'h010, 64'h1111_1111_1111_1111, 64'h0};
        vecs[6]  = '{1'b1, 8'hFF, 9'h011, 64'h2222_2222_2222_2222, 64'h0};
        vecs[7]  = '{1'b1, 8'hFF, 9'h012, 64'h3333_3333_3333_3333, 64'h0};
        vecs[8]  = '{1'b1, 8'hFF, 9'h013, 64'h4444_4444_4444_4444, 64'h0};
        vecs[9]  = '{1'b1, 8'h00, 9'h020, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
        vecs[10] = '{1'b0, 8'hFF, 9'h020, 64'h0, 64'h0};
        vecs[11] = '{1'b1, 8'h81, 9'h1FF, 64'hABFF_FFFF_FFFF_FFCD, 64'h0};
        vecs[12] = '{1'b0, 8'hFF, 9'h1FF, 64'h0, 64'hAB00_0000_0000_00CD};
        burst_exp[0] = 64'h1111_1111_1111_1111;
        burst_exp[1] = 64'h2222_2222_2222_2222;
        burst_exp[2] = 64'h3333_3333_3333_3333;
        burst_exp[3] = 64'h4444_4444_4444_4444;

        // ---- reset state
        RST = 1'b1;
        step(); step(); step();
        chk("rst ack", 64'(wb_ack), 64'd0);
        chk("rst dat_r", wb_dat_r, 64'h0);
        chk("rst init_done", 64'(init_done), 64'd0);
        chk("rst stall", 64'(wb_stall), 64'd1);
        chk("rst ram_a", 64'(ram_a), 64'd0);
        chk("rst ram_we", 64'(ram_we), 64'hFF);

        // ---- initial fill; a request is held during the first cycles
        RST = 1'b0;
        req(1'b1, 8'hFF, 9'h003, 64'h5555_5555_5555_5555);
        wait_init(4000, n, bad, acks);
        chk("init stall cycles", 64'(n), 64'd512);
        chk("init fill seq errs", 64'(bad), 64'd0);
        chk("init acks", 64'(acks), 64'd0);
        chk("init_done", 64'(init_done), 64'd1);
        chk("run stall", 64'(wb_stall), 64'd0);

        // ---- single transactions
        idle();
        for (int i = 0; i < 13; i++) do_txn(vecs[i]);

        // ---- write then read on consecutive cycles
        step();
        req(1'b1, 8'hFF, 9'h007, 64'hCAFE_BABE_1234_5678);
        step();
        req(1'b0, 8'hFF, 9'h007, 64'h0);
        #1;
        chk("raw write ack", 64'(wb_ack), 64'd1);
        chk("raw write ack dat_r", wb_dat_r, 64'h0);
        step();
        idle();
        #1;
        chk("raw read ack", 64'(wb_ack), 64'd1);
        chk("raw read dat_r", wb_dat_r, 64'hCAFE_BABE_1234_5678);

        // ---- 4-read burst, strobe held
        step();
        req(1'b0, 8'hFF, 9'h010, 64'h0);
        #1;
        chk("burst stall 0", 64'(wb_stall), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) req(1'b0, 8'hFF, 9'(9'h010 + i), 64'h0);
            else idle();
            #1;
            chk($sformatf("burst stall %0d", i), 64'(wb_stall), 64'd0);
            chk($sformatf("burst ack %0d", i), 64'(wb_ack), 64'd1);
            chk($sformatf("burst dat %0d", i), wb_dat_r, burst_exp[i-1]);
        end

        // ---- cyc dropped in the ack cycle, then stb without cyc
        step();
        req(1'b0, 8'hFF, 9'h011, 64'h0);
        step();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        chk("drop ack", 64'(wb_ack), 64'd0);
        chk("drop dat_r", wb_dat_r, 64'h0);
        step();
        wb_cyc = 1'b0; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 8'hFF;
        wb_adr = 9'h033; wb_dat_w = 64'h7777_7777_7777_7777;
        #1;
        chk("nocyc ram_en", 64'(ram_en), 64'd0);
        chk("nocyc ram_we", 64'(ram_we), 64'd0);
        chk("nocyc ram_a", 64'(ram_a), 64'd0);
        chk("nocyc ram_di", ram_di, 64'h0);
        step();
        idle();
        #1;
        chk("nocyc ack", 64'(wb_ack), 64'd0);
        do_txn('{1'b0, 8'hFF, 9'h012, 64'h0, 64'h3333_3333_3333_3333});
        do_txn('{1'b0, 8'hFF, 9'h033, 64'h0, 64'h0});

        // ---- reset while an ack is pending
        step();
        req(1'b0, 8'hFF, 9'h013, 64'h0);
        step();
        idle();
        RST = 1'b1;
        #1;
        chk("rst pending ack", 64'(wb_ack), 64'd0);
        chk("rst pending init_done", 64'(init_done), 64'd0);
        step();
        RST = 1'b0;

        // ---- reset pulse at fill counter 200
        wait_init(200, n, bad, acks);
        chk("mid-init count", 64'(n), 64'd200);
        chk("mid-init ram_a", 64'(ram_a), 64'd200);
        RST = 1'b1;
        #1;
        chk("mid-init rst ram_a", 64'(ram_a), 64'd0);
        step();
        RST = 1'b0;
        wait_init(4000, n, bad, acks);
        chk("refill stall cycles", 64'(n), 64'd512);
        chk("refill seq errs", 64'(bad), 64'd0);
        chk("refill init_done", 64'(init_done), 64'd1);

        // ---- everything written earlier is cleared again
        idle();
        do_txn('{1'b0, 8'hFF, 9'h005, 64'h0, 64'h0});
        do_txn('{1'b0, 8'hFF, 9'h1FF, 64'h0, 64'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
